// File: rtl/irq_controller.sv
// Interrupt controller: latches sources as pending, masks them, arbitrates by fixed priority
// (lowest index wins) and sequences the assert / take / ERET handshake with cp0.
// Software access is through a 3-word memory-mapped window on the data-memory bus.
module irq_controller #(
  parameter int unsigned NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0010
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        address,
  input  logic [31:0]        wr_data,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               TakenInterrupt,
  input  logic               ERET,
  output logic [31:0]        rd_data,
  output logic               IRQAddress,
  output logic               InterruptLine,
  output logic [2:0]         active_id
);

  typedef enum logic [1:0] {StIdle, StAssert, StService} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] eligible, w1c, take_clr;
  logic [2:0]         active_id_q, active_id_d, sel;
  logic [29:0]        word_off;
  logic               sel_pending, sel_mask, sel_active, reg_wr, take;

  // Upper store-data bits and the byte offset within a word are don't-cares.
  logic unused_bits;
  assign unused_bits = ^{wr_data, address[1:0]};

  // Offset in words from the window base; anything past +2 (including wrap) misses.
  assign word_off    = address[31:2] - BASE_ADDR[31:2];
  assign sel_pending = (word_off == 30'd0);
  assign sel_mask    = (word_off == 30'd1);
  assign sel_active  = (word_off == 30'd2);
  assign IRQAddress  = sel_pending | sel_mask | sel_active;
  assign reg_wr      = IRQAddress & MemWrite;

  assign eligible      = pending_q & mask_q;
  assign take          = (state_q == StAssert) & TakenInterrupt;
  assign InterruptLine = (state_q == StAssert);
  assign active_id     = active_id_q;

  // Fixed-priority pick: scan from the top so the lowest set index is the last to win.
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = 3'(i);
    end
  end

  // Pending/mask next state; a new source request beats any clear in the same cycle.
  always_comb begin
    w1c      = (reg_wr && sel_pending) ? wr_data[NUM_SRC-1:0] : '0;
    take_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      take_clr[i] = take && (active_id_q == 3'(i));
    end
    pending_d = irq_src | (pending_q & ~w1c & ~take_clr);
    mask_d    = (reg_wr && sel_mask) ? wr_data[NUM_SRC-1:0] : mask_q;
  end

  // Handshake FSM next state and the arbitrated / frozen source id.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          state_d     = StAssert;
          active_id_d = sel;
        end
      end
      StAssert: begin
        if (TakenInterrupt) begin
          state_d = StService;
        end else if (!(|eligible)) begin
          state_d = StIdle;
        end else begin
          active_id_d = sel;
        end
      end
      StService: begin
        if (ERET) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Register read mux; zero whenever the window is not being loaded from.
  always_comb begin
    rd_data = '0;
    if (MemRead) begin
      if (sel_pending) begin
        rd_data[NUM_SRC-1:0] = pending_q;
      end else if (sel_mask) begin
        rd_data[NUM_SRC-1:0] = mask_q;
      end else if (sel_active) begin
        rd_data[3:0] = {state_q == StService, active_id_q};
      end
    end
  end

  // State registers with synchronous reset; reset drops any handshake in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      mask_q      <= '0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      active_id_q <= active_id_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a randomized run
// compared against a behavioural model of the controller.
module tb_irq_controller;

  localparam int unsigned NUM_SRC = 4;
  localparam logic [31:0] BASE    = 32'hFFFF0010;
  localparam int unsigned ALL     = (1 << NUM_SRC) - 1;

  logic               clock = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] irq_src;
  logic [31:0]        address, wr_data;
  logic               MemRead, MemWrite, TakenInterrupt, ERET;
  logic [31:0]        rd_data;
  logic               IRQAddress, InterruptLine;
  logic [2:0]         active_id;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model state.
  int unsigned m_pend, m_mask, m_id;
  bit          m_asserting, m_serving;

  irq_controller #(
    .NUM_SRC  (NUM_SRC),
    .BASE_ADDR(BASE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .irq_src       (irq_src),
    .address       (address),
    .wr_data       (wr_data),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .TakenInterrupt(TakenInterrupt),
    .ERET          (ERET),
    .rd_data       (rd_data),
    .IRQAddress    (IRQAddress),
    .InterruptLine (InterruptLine),
    .active_id     (active_id)
  );

  always #5 clock = ~clock;

  function automatic bit in_window(logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd12);
  endfunction

  function automatic int unsigned lowest(int unsigned v);
    int unsigned n = 0;
    while (((v >> n) & 1) == 0) n++;
    return n;
  endfunction

  function automatic logic [31:0] model_rd();
    int unsigned off;
    if (!(MemRead && in_window(address))) return 32'h0;
    off = (address - BASE) / 4;
    if (off == 0) return m_pend;
    if (off == 1) return m_mask;
    return (m_serving ? 32'd8 : 32'd0) + m_id;
  endfunction

  // Advance the model using the inputs presented for the coming edge.
  task automatic model_step();
    int unsigned elig, np, nm, nid;
    bit          na, ns;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_id = 0; m_asserting = 0; m_serving = 0;
      return;
    end
    elig = m_pend & m_mask;
    np = m_pend; nm = m_mask; nid = m_id; na = m_asserting; ns = m_serving;
    if (MemWrite && in_window(address)) begin
      if ((address - BASE) / 4 == 0) np = np & ~wr_data;
      else if ((address - BASE) / 4 == 1) nm = wr_data & ALL;
    end
    if (m_asserting) begin
      if (TakenInterrupt) begin
        na = 0; ns = 1;
        np = np & ~(32'd1 << m_id);
      end else if (elig == 0) begin
        na = 0;
      end else begin
        nid = lowest(elig);
      end
    end else if (m_serving) begin
      if (ERET) ns = 0;
    end else if (elig != 0) begin
      na = 1;
      nid = lowest(elig);
    end
    np = (np | irq_src) & ALL;
    m_pend = np; m_mask = nm; m_id = nid; m_asserting = na; m_serving = ns;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic write_reg(input int unsigned off, input logic [31:0] data);
    address  = BASE + 32'(off * 4);
    wr_data  = data;
    MemWrite = 1'b1;
    cycle();
    MemWrite = 1'b0;
    address  = 32'h0;
  endtask

  task automatic read_reg(input int unsigned off, output logic [31:0] v);
    address = BASE + 32'(off * 4);
    MemRead = 1'b1;
    #1;
    v       = rd_data;
    MemRead = 1'b0;
    address = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    tests_run++;
    if (InterruptLine !== 1'b0) begin
      tests_failed++; $display("FAIL reset_line: got %0b expected 0", InterruptLine);
    end
    tests_run++;
    if (active_id !== 3'd0) begin
      tests_failed++; $display("FAIL reset_id: got %0d expected 0", active_id);
    end
    for (int r = 0; r < 3; r++) begin
      read_reg(r, v);
      tests_run++;
      if (v !== 32'h0) begin
        tests_failed++; $display("FAIL reset_reg%0d: got %h expected 0", r, v);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] v;
    do_reset();
    write_reg(1, 32'h1);
    irq_src = 4'b0001;
    cycle();
    irq_src = '0;
    tests_run++;
    if (InterruptLine !== 1'b0) begin
      tests_failed++; $display("FAIL basic_line_early: got %0b expected 0", InterruptLine);
    end
    cycle();
    tests_run++;
    if (InterruptLine !== 1'b1 || active_id !== 3'd0) begin
      tests_failed++;
      $display("FAIL basic_assert: got line=%0b id=%0d expected line=1 id=0",
               InterruptLine, active_id);
    end
    TakenInterrupt = 1'b1;
    cycle();
    TakenInterrupt = 1'b0;
    tests_run++;
    if (InterruptLine !== 1'b0) begin
      tests_failed++; $display("FAIL basic_taken_line: got %0b expected 0", InterruptLine);
    end
    read_reg(0, v);
    tests_run++;
    if (v !== 32'h0) begin
      tests_failed++; $display("FAIL basic_pending: got %h expected 0", v);
    end
    read_reg(2, v);
    tests_run++;
    if (v !== 32'h8) begin
      tests_failed++; $display("FAIL basic_active: got %h expected 8", v);
    end
    ERET = 1'b1;
    cycle();
    ERET = 1'b0;
    cycle();
    tests_run++;
    if (InterruptLine !== 1'b0) begin
      tests_failed++; $display("FAIL basic_after_eret: got %0b expected 0", InterruptLine);
    end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    do_reset();
    write_reg(1, 32'hF);
    irq_src = 4'b1100;
    cycle();
    irq_src = '0;
    cycle();
    tests_run++;
    if (InterruptLine !== 1'b1 || active_id !== 3'd2) begin
      tests_failed++;
      $display("FAIL prio_first: got line=%0b id=%0d expected line=1 id=2",
               InterruptLine, active_id);
    end
    irq_src = 4'b0010;
    cycle();
    irq_src = '0;
    cycle();
    tests_run++;
    if (InterruptLine !== 1'b1 || active_id !== 3'd1) begin
      tests_failed++;
      $display("FAIL prio_rearb: got line=%0b id=%0d expected line=1 id=1",
               InterruptLine, active_id);
    end
    TakenInterrupt = 1'b1;
    cycle();
    TakenInterrupt = 1'b0;
    read_reg(2, v);
    tests_run++;
    if (v !== 32'h9) begin
      tests_failed++; $display("FAIL prio_active: got %h expected 9", v);
    end
    read_reg(0, v);
    tests_run++;
    if (v !== 32'hC) begin
      tests_failed++; $display("FAIL prio_pending: got %h expected c", v);
    end
  endtask

  task automatic test_no_nesting();
    logic [31:0] v;
    do_reset();
    write_reg(1, 32'hF);
    irq_src = 4'b0001;
    cycle();
    irq_src = '0;
    cycle();
    TakenInterrupt = 1'b1;
    cycle();
    TakenInterrupt = 1'b0;
    irq_src = 4'b1000;
    cycle();
    irq_src = '0;
    for (int n = 0; n < 4; n++) begin
      tests_run++;
      if (InterruptLine !== 1'b0) begin
        tests_failed++; $display("FAIL nest_line%0d: got %0b expected 0", n, InterruptLine);
      end
      cycle();
    end
    ERET = 1'b1;
    cycle();
    ERET = 1'b0;
    tests_run++;
    if (InterruptLine !== 1'b0) begin
      tests_failed++; $display("FAIL nest_eret_line: got %0b expected 0", InterruptLine);
    end
    read_reg(2, v);
    tests_run++;
    if (v !== 32'h0) begin
      tests_failed++; $display("FAIL nest_eret_active: got %h expected 0", v);
    end
    cycle();
    tests_run++;
    if (InterruptLine !== 1'b1 || active_id !== 3'd3) begin
      tests_failed++;
      $display("FAIL nest_reassert: got line=%0b id=%0d expected line=1 id=3",
               InterruptLine, active_id);
    end
  endtask

  task automatic test_mask();
    logic [31:0] v;
    do_reset();
    irq_src = 4'b0010;
    cycle();
    irq_src = '0;
    cycle();
    cycle();
    tests_run++;
    if (InterruptLine !== 1'b0) begin
      tests_failed++; $display("FAIL mask_blocked: got %0b expected 0", InterruptLine);
    end
    read_reg(0, v);
    tests_run++;
    if (v !== 32'h2) begin
      tests_failed++; $display("FAIL mask_pending: got %h expected 2", v);
    end
    write_reg(1, 32'h2);
    tests_run++;
    if (InterruptLine !== 1'b0) begin
      tests_failed++; $display("FAIL mask_write_edge: got %0b expected 0", InterruptLine);
    end
    cycle();
    tests_run++;
    if (InterruptLine !== 1'b1 || active_id !== 3'd1) begin
      tests_failed++;
      $display("FAIL mask_enable: got line=%0b id=%0d expected line=1 id=1",
               InterruptLine, active_id);
    end
    write_reg(1, 32'h0);
    cycle();
    tests_run++;
    if (InterruptLine !== 1'b0) begin
      tests_failed++; $display("FAIL mask_withdraw: got %0b expected 0", InterruptLine);
    end
    read_reg(0, v);
    tests_run++;
    if (v !== 32'h2) begin
      tests_failed++; $display("FAIL mask_pending_kept: got %h expected 2", v);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] v;
    do_reset();
    irq_src = 4'b0001;
    cycle();
    address  = BASE;
    wr_data  = 32'h1;
    MemWrite = 1'b1;
    cycle();
    MemWrite = 1'b0;
    irq_src  = '0;
    address  = 32'h0;
    read_reg(0, v);
    tests_run++;
    if (v !== 32'h1) begin
      tests_failed++; $display("FAIL w1c_set_wins: got %h expected 1", v);
    end
    write_reg(0, 32'h1);
    read_reg(0, v);
    tests_run++;
    if (v !== 32'h0) begin
      tests_failed++; $display("FAIL w1c_clear: got %h expected 0", v);
    end
    address  = BASE + 32'd6;
    wr_data  = 32'hA;
    MemWrite = 1'b1;
    cycle();
    MemWrite = 1'b0;
    address  = BASE + 32'd5;
    MemRead  = 1'b1;
    #1;
    tests_run++;
    if (rd_data !== 32'hA || IRQAddress !== 1'b1) begin
      tests_failed++;
      $display("FAIL w1c_alias: got rd=%h hit=%0b expected rd=a hit=1", rd_data, IRQAddress);
    end
    address = BASE + 32'd12;
    #1;
    tests_run++;
    if (rd_data !== 32'h0 || IRQAddress !== 1'b0) begin
      tests_failed++;
      $display("FAIL unmapped_above: got rd=%h hit=%0b expected rd=0 hit=0", rd_data, IRQAddress);
    end
    address = BASE - 32'd4;
    #1;
    tests_run++;
    if (rd_data !== 32'h0 || IRQAddress !== 1'b0) begin
      tests_failed++;
      $display("FAIL unmapped_below: got rd=%h hit=%0b expected rd=0 hit=0", rd_data, IRQAddress);
    end
    MemRead = 1'b0;
    address = 32'h0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    do_reset();
    write_reg(1, 32'hF);
    irq_src = 4'b0101;
    cycle();
    irq_src = '0;
    cycle();
    tests_run++;
    if (InterruptLine !== 1'b1) begin
      tests_failed++; $display("FAIL rmid_pre_assert: got %0b expected 1", InterruptLine);
    end
    reset   = 1'b1;
    irq_src = 4'hF;
    cycle();
    reset   = 1'b0;
    irq_src = '0;
    tests_run++;
    if (InterruptLine !== 1'b0 || active_id !== 3'd0) begin
      tests_failed++;
      $display("FAIL rmid_assert_out: got line=%0b id=%0d expected 0 0", InterruptLine, active_id);
    end
    for (int r = 0; r < 3; r++) begin
      read_reg(r, v);
      tests_run++;
      if (v !== 32'h0) begin
        tests_failed++; $display("FAIL rmid_assert_reg%0d: got %h expected 0", r, v);
      end
    end
    write_reg(1, 32'hF);
    irq_src = 4'b0100;
    cycle();
    irq_src = '0;
    cycle();
    TakenInterrupt = 1'b1;
    cycle();
    TakenInterrupt = 1'b0;
    read_reg(2, v);
    tests_run++;
    if (v !== 32'hA) begin
      tests_failed++; $display("FAIL rmid_pre_service: got %h expected a", v);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    tests_run++;
    if (InterruptLine !== 1'b0 || active_id !== 3'd0) begin
      tests_failed++;
      $display("FAIL rmid_service_out: got line=%0b id=%0d expected 0 0", InterruptLine, active_id);
    end
    read_reg(2, v);
    tests_run++;
    if (v !== 32'h0) begin
      tests_failed++; $display("FAIL rmid_service_active: got %h expected 0", v);
    end
    ERET = 1'b1;
    cycle();
    ERET = 1'b0;
    tests_run++;
    if (InterruptLine !== 1'b0) begin
      tests_failed++; $display("FAIL rmid_stray_eret: got %0b expected 0", InterruptLine);
    end
  endtask

  task automatic test_random();
    do_reset();
    write_reg(1, 32'hF);
    for (int n = 0; n < 800; n++) begin
      reset   = ($urandom_range(0, 99) == 0);
      irq_src = ($urandom_range(0, 4) == 0) ? NUM_SRC'($urandom) : '0;
      case ($urandom_range(0, 4))
        0, 1:    address = BASE + 32'($urandom_range(0, 11));
        2:       address = BASE + 32'd12 + 32'($urandom_range(0, 3));
        3:       address = BASE - 32'd1 - 32'($urandom_range(0, 3));
        default: address = $urandom;
      endcase
      wr_data        = $urandom;
      MemRead        = 1'($urandom_range(0, 1));
      MemWrite       = ($urandom_range(0, 3) == 0);
      TakenInterrupt = ($urandom_range(0, 2) == 0);
      ERET           = ($urandom_range(0, 3) == 0);
      #1;
      tests_run++;
      if (InterruptLine !== m_asserting || active_id !== 3'(m_id)) begin
        tests_failed++;
        $display("FAIL rand_state cycle %0d: got line=%0b id=%0d expected line=%0b id=%0d",
                 n, InterruptLine, active_id, m_asserting, m_id);
      end
      tests_run++;
      if (IRQAddress !== in_window(address) || rd_data !== model_rd()) begin
        tests_failed++;
        $display("FAIL rand_bus cycle %0d addr=%h: got hit=%0b rd=%h expected hit=%0b rd=%h",
                 n, address, IRQAddress, rd_data, in_window(address), model_rd());
      end
      cycle();
    end
    reset = 1'b0; irq_src = '0; address = 32'h0; MemRead = 1'b0; MemWrite = 1'b0;
    TakenInterrupt = 1'b0; ERET = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; address = 32'h0; wr_data = 32'h0;
    MemRead = 1'b0; MemWrite = 1'b0; TakenInterrupt = 1'b0; ERET = 1'b0;
    m_pend = 0; m_mask = 0; m_id = 0; m_asserting = 0; m_serving = 0;
    test_reset();
    test_basic();
    test_priority();
    test_no_nesting();
    test_mask();
    test_w1c();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
